// File: rtl/rate_period_decoder.sv
// Measures the cycle interval between rate-divider ticks and recovers the speed
// select that produced it, with lock, bad-interval and timeout status.
module rate_period_decoder #(
    parameter int P1  = 25000000,
    parameter int P2  = 50000000,
    parameter int P3  = 100000000,
    parameter int TOL = 1024
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        tick,
    output logic [26:0] period,
    output logic        period_valid,
    output logic [1:0]  speed_code,
    output logic        locked,
    output logic        bad_period,
    output logic        timeout
);

    localparam logic [26:0] LO1  = 27'(P1 - TOL);
    localparam logic [26:0] HI1  = 27'(P1 + TOL);
    localparam logic [26:0] LO2  = 27'(P2 - TOL);
    localparam logic [26:0] HI2  = 27'(P2 + TOL);
    localparam logic [26:0] LO3  = 27'(P3 - TOL);
    localparam logic [26:0] HI3  = 27'(P3 + TOL);
    localparam logic [26:0] TMAX = 27'(P3 + TOL);

    typedef enum logic {IDLE, MEASURE} state_t;

    state_t      state, state_n;
    logic [26:0] cnt, cnt_n;
    logic [1:0]  cand, cand_n;
    logic        cand_v, cand_v_n;
    logic [26:0] period_n;
    logic        period_valid_n, bad_period_n, locked_n, timeout_n;
    logic [1:0]  speed_code_n;
    logic        match;
    logic [1:0]  cls;

    // Interval classifier: code 00 only for back-to-back ticks, else windowed.
    always_comb begin
        match = 1'b1;
        cls   = 2'b00;
        if (cnt == 27'd1) begin
            cls = 2'b00;
        end else if (cnt >= LO1 && cnt <= HI1) begin
            cls = 2'b01;
        end else if (cnt >= LO2 && cnt <= HI2) begin
            cls = 2'b10;
        end else if (cnt >= LO3 && cnt <= HI3) begin
            cls = 2'b11;
        end else begin
            match = 1'b0;
        end
    end

    always_comb begin
        state_n        = state;
        cnt_n          = cnt;
        cand_n         = cand;
        cand_v_n       = cand_v;
        period_n       = period;
        period_valid_n = 1'b0;
        bad_period_n   = 1'b0;
        speed_code_n   = speed_code;
        locked_n       = locked;
        timeout_n      = timeout;
        case (state)
            IDLE: begin
                if (tick) begin
                    state_n   = MEASURE;
                    cnt_n     = 27'd1;
                    timeout_n = 1'b0;
                end
            end
            MEASURE: begin
                // A tick on the timeout edge takes priority over the timeout.
                if (tick) begin
                    period_n       = cnt;
                    period_valid_n = 1'b1;
                    cnt_n          = 27'd1;
                    if (match) begin
                        if (cand_v && cand == cls) begin
                            speed_code_n = cls;
                            locked_n     = 1'b1;
                        end else begin
                            cand_n   = cls;
                            cand_v_n = 1'b1;
                            locked_n = 1'b0;
                        end
                    end else begin
                        bad_period_n = 1'b1;
                        locked_n     = 1'b0;
                        cand_v_n     = 1'b0;
                    end
                end else if (cnt == TMAX) begin
                    timeout_n = 1'b1;
                    locked_n  = 1'b0;
                    cand_v_n  = 1'b0;
                    cnt_n     = 27'd0;
                    state_n   = IDLE;
                end else begin
                    cnt_n = cnt + 27'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= 27'd0;
            cand         <= 2'b00;
            cand_v       <= 1'b0;
            period       <= 27'd0;
            period_valid <= 1'b0;
            bad_period   <= 1'b0;
            speed_code   <= 2'b00;
            locked       <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            cand         <= cand_n;
            cand_v       <= cand_v_n;
            period       <= period_n;
            period_valid <= period_valid_n;
            bad_period   <= bad_period_n;
            speed_code   <= speed_code_n;
            locked       <= locked_n;
            timeout      <= timeout_n;
        end
    end

endmodule

// File: tb/tb_rate_period_decoder.sv
// Directed self-checking bench for rate_period_decoder with small periods
// (P1=10, P2=20, P3=40, TOL=2).
module tb_rate_period_decoder;

    logic        clock;
    logic        reset;
    logic        tick;
    logic [26:0] period;
    logic        period_valid;
    logic [1:0]  speed_code;
    logic        locked;
    logic        bad_period;
    logic        timeout;

    int checks   = 0;
    int failures = 0;

    rate_period_decoder #(.P1(10), .P2(20), .P3(40), .TOL(2)) dut (
        .clock        (clock),
        .reset        (reset),
        .tick         (tick),
        .period       (period),
        .period_valid (period_valid),
        .speed_code   (speed_code),
        .locked       (locked),
        .bad_period   (bad_period),
        .timeout      (timeout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // One clock edge with the given tick value; returns 1 time unit after the edge.
    task automatic applyStimulus(input logic t);
        @(negedge clock);
        tick = t;
        @(posedge clock);
        #1;
    endtask

    task automatic tickAfter(input int n);
        for (int i = 0; i < n - 1; i++) applyStimulus(1'b0);
        applyStimulus(1'b1);
    endtask

    task automatic pulseReset();
        @(negedge clock);
        reset = 1'b1;
        tick  = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_period"}, 32'(period), 0);
        checkOutput({tag, "_pv"}, 32'(period_valid), 0);
        checkOutput({tag, "_speed"}, 32'(speed_code), 0);
        checkOutput({tag, "_locked"}, 32'(locked), 0);
        checkOutput({tag, "_bad"}, 32'(bad_period), 0);
        checkOutput({tag, "_timeout"}, 32'(timeout), 0);
    endtask

    initial begin
        reset = 1'b1;
        tick  = 1'b0;
        applyStimulus(1'b0);
        applyStimulus(1'b0);
        reset = 1'b0;
        checkAllZero("rst");

        // Back-to-back ticks recover code 00.
        applyStimulus(1'b1);
        checkOutput("b2b_t1_pv", 32'(period_valid), 0);
        applyStimulus(1'b1);
        checkOutput("b2b_t2_pv", 32'(period_valid), 1);
        checkOutput("b2b_t2_period", 32'(period), 1);
        checkOutput("b2b_t2_locked", 32'(locked), 0);
        applyStimulus(1'b1);
        checkOutput("b2b_t3_pv", 32'(period_valid), 1);
        checkOutput("b2b_t3_period", 32'(period), 1);
        checkOutput("b2b_t3_locked", 32'(locked), 1);
        checkOutput("b2b_t3_speed", 32'(speed_code), 0);
        applyStimulus(1'b1);
        checkOutput("b2b_t4_period", 32'(period), 1);
        checkOutput("b2b_t4_locked", 32'(locked), 1);
        applyStimulus(1'b0);
        checkOutput("b2b_pv_drop", 32'(period_valid), 0);

        // Ticks every 20 cycles lock to code 10.
        pulseReset();
        applyStimulus(1'b1);
        checkOutput("p20_t1_pv", 32'(period_valid), 0);
        tickAfter(20);
        checkOutput("p20_t2_period", 32'(period), 20);
        checkOutput("p20_t2_pv", 32'(period_valid), 1);
        checkOutput("p20_t2_locked", 32'(locked), 0);
        checkOutput("p20_t2_bad", 32'(bad_period), 0);
        tickAfter(20);
        checkOutput("p20_t3_period", 32'(period), 20);
        checkOutput("p20_t3_speed", 32'(speed_code), 2);
        checkOutput("p20_t3_locked", 32'(locked), 1);
        checkOutput("p20_t3_bad", 32'(bad_period), 0);

        // Window edges 18 and 22 hold the lock; 23 falls outside.
        tickAfter(19);
        checkOutput("w19_period", 32'(period), 19);
        checkOutput("w19_locked", 32'(locked), 1);
        tickAfter(22);
        checkOutput("w22_period", 32'(period), 22);
        checkOutput("w22_locked", 32'(locked), 1);
        checkOutput("w22_bad", 32'(bad_period), 0);
        tickAfter(18);
        checkOutput("w18_period", 32'(period), 18);
        checkOutput("w18_locked", 32'(locked), 1);
        checkOutput("w18_bad", 32'(bad_period), 0);
        tickAfter(23);
        checkOutput("w23_period", 32'(period), 23);
        checkOutput("w23_pv", 32'(period_valid), 1);
        checkOutput("w23_bad", 32'(bad_period), 1);
        checkOutput("w23_locked", 32'(locked), 0);
        checkOutput("w23_speed", 32'(speed_code), 2);
        applyStimulus(1'b0);
        checkOutput("w23_bad_drop", 32'(bad_period), 0);
        tickAfter(22);
        tickAfter(23);
        checkOutput("w23b_bad", 32'(bad_period), 1);
        checkOutput("w23b_locked", 32'(locked), 0);

        // Lock to code 11, then let the tick stream stop.
        tickAfter(40);
        checkOutput("p40_t1_locked", 32'(locked), 0);
        tickAfter(40);
        checkOutput("p40_t2_speed", 32'(speed_code), 3);
        checkOutput("p40_t2_locked", 32'(locked), 1);
        for (int i = 0; i < 41; i++) applyStimulus(1'b0);
        checkOutput("to_edge41", 32'(timeout), 0);
        applyStimulus(1'b0);
        checkOutput("to_edge42", 32'(timeout), 1);
        checkOutput("to_locked", 32'(locked), 0);
        checkOutput("to_speed", 32'(speed_code), 3);
        checkOutput("to_period", 32'(period), 40);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0);
        checkOutput("to_level", 32'(timeout), 1);
        applyStimulus(1'b1);
        checkOutput("to_clear", 32'(timeout), 0);
        checkOutput("to_clear_pv", 32'(period_valid), 0);
        tickAfter(40);
        checkOutput("to_p40_period", 32'(period), 40);
        checkOutput("to_p40_pv", 32'(period_valid), 1);
        checkOutput("to_p40_locked", 32'(locked), 0);

        // Interval exactly at the timeout limit is a valid code 11 interval.
        tickAfter(42);
        checkOutput("p42_period", 32'(period), 42);
        checkOutput("p42_timeout", 32'(timeout), 0);
        checkOutput("p42_bad", 32'(bad_period), 0);
        checkOutput("p42_locked", 32'(locked), 1);
        checkOutput("p42_speed", 32'(speed_code), 3);
        applyStimulus(1'b0);
        checkOutput("p42_timeout_after", 32'(timeout), 0);

        // Reset partway through an interval discards it.
        for (int i = 0; i < 8; i++) applyStimulus(1'b0);
        pulseReset();
        checkAllZero("midrst");
        for (int i = 0; i < 5; i++) applyStimulus(1'b0);
        applyStimulus(1'b1);
        checkOutput("midrst_t1_pv", 32'(period_valid), 0);
        tickAfter(20);
        checkOutput("midrst_t2_pv", 32'(period_valid), 1);
        checkOutput("midrst_t2_period", 32'(period), 20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
